// File: rtl/uart_hex_tx.sv
// Button-triggered UART reporter: sends data as two hex digits plus CR LF.
// Define UART_HEX_TX_PARITY_EN to add an even-parity bit to every frame.
module uart_hex_tx #(
   parameter int CLK_FREQ        = 100_000_000,
   parameter int BAUD            = 115200,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy
);

   localparam int CPB = CLK_FREQ / BAUD;
   localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_HEX_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t state, next;

   logic          sync1, sync2;
   logic          db, db_prev;
   logic [DW-1:0] db_cnt;
   logic          trigger;

   logic [BW-1:0] baud_cnt;
   logic          bit_done;
   logic [2:0]    bit_idx;
   logic [1:0]    char_idx;
   logic [7:0]    snap;
   logic [7:0]    ch;

   function automatic logic [7:0] hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         db      <= 1'b0;
         db_prev <= 1'b0;
         db_cnt  <= '0;
      end else begin
         sync1   <= btn;
         sync2   <= sync1;
         db_prev <= db;
         if (sync2 != db) begin
            if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
               db     <= sync2;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign trigger  = db & ~db_prev;
   assign bit_done = (baud_cnt == BW'(CPB - 1));

   always_comb begin
      unique case (char_idx)
         2'd0:    ch = hex(snap[7:4]);
         2'd1:    ch = hex(snap[3:0]);
         2'd2:    ch = 8'h0D;
         default: ch = 8'h0A;
      endcase
   end

   // Baud counter restarts on every bit boundary and idles at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         char_idx <= '0;
         snap     <= '0;
      end else begin
         if (state == IDLE || bit_done)
            baud_cnt <= '0;
         else
            baud_cnt <= baud_cnt + 1'b1;
         if (state == IDLE && trigger) begin
            snap     <= data;
            char_idx <= '0;
         end
         if (state == START)
            bit_idx <= '0;
         else if (state == DATA && bit_done)
            bit_idx <= bit_idx + 1'b1;
         if (state == STOP && bit_done && char_idx != 2'd3)
            char_idx <= char_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next;
   end

   always_comb begin
      next = state;
      unique case (state)
         IDLE:  if (trigger) next = START;
         START: if (bit_done) next = DATA;
         DATA: begin
            if (bit_done && bit_idx == 3'd7) begin
`ifdef UART_HEX_TX_PARITY_EN
               next = PARITY;
`else
               next = STOP;
`endif
            end
         end
`ifdef UART_HEX_TX_PARITY_EN
         PARITY: if (bit_done) next = STOP;
`endif
         STOP: begin
            if (bit_done)
               next = (char_idx != 2'd3) ? START : IDLE;
         end
         default: next = IDLE;
      endcase
   end

   always_comb begin
      tx   = 1'b1;
      busy = (state != IDLE);
      unique case (state)
         IDLE:   tx = 1'b1;
         START:  tx = 1'b0;
         DATA:   tx = ch[bit_idx];
`ifdef UART_HEX_TX_PARITY_EN
         PARITY: tx = ^ch;
`endif
         STOP:   tx = 1'b1;
         default: tx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Self-checking bench for uart_hex_tx: decodes tx and compares with a
// hex/CR/LF message model derived from the snapshotted data value.
module tb_uart_hex_tx;

   localparam int CPB = 10;
`ifdef UART_HEX_TX_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       btn;
   logic [7:0] data;
   logic       tx;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int busy_cyc = 0;
   int msgs = 0;
   logic busy_q = 1'b0;

   uart_hex_tx #(
      .CLK_FREQ(1000),
      .BAUD(100),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn(btn),
      .data(data),
      .tx(tx),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (busy === 1'b1) busy_cyc = busy_cyc + 1;
      if (busy === 1'b1 && busy_q !== 1'b1) msgs = msgs + 1;
      busy_q = busy;
   end

   function automatic logic [7:0] exp_char(input logic [7:0] d, input int i);
      int n;
      if (i == 2) return 8'h0D;
      if (i == 3) return 8'h0A;
      n = (i == 0) ? int'(d) / 16 : int'(d) % 16;
      if (n < 10) return 8'(48 + n);
      return 8'(65 + n - 10);
   endfunction

   task automatic hold(input int n);
      btn = 1'b1;
      repeat (n) @(negedge clk);
      btn = 1'b0;
   endtask

   task automatic wait_busy(input string tag);
      bit ok = 0;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (busy === 1'b1) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_busy_timeout got busy=%b want 1", tag, busy);
      end
   endtask

   task automatic wait_idle(input string tag);
      bit ok = 0;
      for (int t = 0; t < 2000; t++) begin
         if (busy === 1'b0) begin ok = 1; break; end
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_idle_timeout got busy=%b want 0", tag, busy);
      end
   endtask

   task automatic recv_char(input string tag, output logic [7:0] b,
                            output bit ok, output int gap);
      ok = 0;
      b = '0;
      gap = 0;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (tx === 1'b0) begin ok = 1; gap = t + 1; break; end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s_rx_timeout got tx=%b want start bit", tag, tx);
         return;
      end
      repeat (CPB / 2) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL %s_start got %b want 0", tag, tx);
      end
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = tx;
      end
`ifdef UART_HEX_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      checks++;
      if (tx !== ^b) begin
         errors++;
         $display("FAIL %s_parity got %b want %b", tag, tx, ^b);
      end
`endif
      repeat (CPB) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL %s_stop got %b want 1", tag, tx);
      end
   endtask

   task automatic recv_msg(input logic [7:0] d, input string tag);
      logic [7:0] b;
      bit ok;
      int gap;
      for (int i = 0; i < 4; i++) begin
         recv_char(tag, b, ok, gap);
         if (!ok) return;
         checks++;
         if (b !== exp_char(d, i)) begin
            errors++;
            $display("FAIL %s_char%0d got %h want %h", tag, i, b, exp_char(d, i));
         end
         if (i > 0) begin
            checks++;
            if (gap != CPB - CPB / 2) begin
               errors++;
               $display("FAIL %s_gap%0d got %0d want %0d", tag, i, gap, CPB - CPB / 2);
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      btn = 1'b0;
      data = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset got tx=%b busy=%b want tx=1 busy=0", tx, busy);
      end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle got tx=%b busy=%b want 1/0", tx, busy);
      end
   endtask

   task automatic test_basic;
      int b0 = busy_cyc;
      data = 8'hA5;
      fork
         hold(20);
         recv_msg(8'hA5, "basic");
      join
      wait_idle("basic");
      checks++;
      if (busy_cyc - b0 != 4 * FRAME * CPB) begin
         errors++;
         $display("FAIL basic_busy_len got %0d want %0d", busy_cyc - b0, 4 * FRAME * CPB);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL basic_tx_after got %b want 1", tx);
      end
   endtask

   task automatic test_glitch;
      int m0 = msgs;
      for (int i = 0; i < 5; i++) begin
         btn = 1'b1;
         repeat (3) @(negedge clk);
         btn = 1'b0;
         repeat (3) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (msgs != m0 || tx !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch got msgs=%0d tx=%b busy=%b want msgs=%0d tx=1 busy=0",
                  msgs - m0, tx, busy, 0);
      end
   endtask

   task automatic test_hold_repress;
      int m0 = msgs;
      data = 8'h0F;
      fork
         hold(450);
         recv_msg(8'h0F, "hold1");
      join
      wait_idle("hold1");
      repeat (20) @(negedge clk);
      fork
         hold(20);
         recv_msg(8'h0F, "hold2");
      join
      wait_idle("hold2");
      repeat (20) @(negedge clk);
      fork
         begin
            hold(20);
            repeat (80) @(negedge clk);
            hold(20);
         end
         recv_msg(8'h0F, "hold3");
      join
      wait_idle("hold3");
      repeat (100) @(negedge clk);
      checks++;
      if (msgs - m0 != 3 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_press_dropped got msgs=%0d busy=%b want 3 busy=0",
                  msgs - m0, busy);
      end
   endtask

   task automatic test_data_change;
      data = 8'h12;
      btn = 1'b1;
      fork
         begin
            wait_busy("dchg");
            checks++;
            if (tx !== 1'b0) begin
               errors++;
               $display("FAIL first_start_latency got tx=%b want 0", tx);
            end
            data = 8'hFF;
            repeat (20) @(negedge clk);
            btn = 1'b0;
         end
         recv_msg(8'h12, "dchg");
      join
      wait_idle("dchg");
      repeat (20) @(negedge clk);
   endtask

   task automatic test_random;
      logic [7:0] d;
      for (int k = 0; k < 4; k++) begin
         d = 8'($urandom);
         data = d;
         fork
            hold(10 + int'($urandom_range(0, 20)));
            recv_msg(d, "rand");
         join
         data = 8'($urandom);
         wait_idle("rand");
         repeat (20) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid;
      int m0;
      data = 8'h00;
      btn = 1'b1;
      wait_busy("rstmid");
      btn = 1'b0;
      repeat (FRAME * CPB + CPB + 3 * CPB + CPB / 2) @(negedge clk);
      checks++;
      if (tx !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre got tx=%b busy=%b want 0/1", tx, busy);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async got tx=%b busy=%b want 1/0", tx, busy);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m0 = msgs;
      repeat (100) @(negedge clk);
      checks++;
      if (msgs != m0 || tx !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_quiet got msgs=%0d tx=%b busy=%b want 0 1 0",
                  msgs - m0, tx, busy);
      end
   endtask

   task automatic test_held_through_reset;
      int m0;
      data = 8'h7E;
      btn = 1'b1;
      rst = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      m0 = msgs;
      recv_msg(8'h7E, "heldrst");
      btn = 1'b0;
      wait_idle("heldrst");
      repeat (50) @(negedge clk);
      checks++;
      if (msgs - m0 != 1) begin
         errors++;
         $display("FAIL heldrst_count got %0d want 1", msgs - m0);
      end
   endtask

   initial begin
      rst = 1'b1;
      btn = 1'b0;
      data = 8'h00;
      test_reset;
      test_basic;
      test_glitch;
      test_hold_repress;
      test_data_change;
      test_random;
      test_reset_mid;
      test_held_through_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
